demux_reg: RTL and testbench

DEMUX_REG -- requirements
Module: demux_reg

---
 rtl/demux_reg.sv | 139 +++++++++++++
 tb/tb_demux_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_reg.sv
// Registered 1-to-NUM_OUTPUTS demultiplexer with a single holding entry,
// per-output valid/ready handshakes and sticky accounting of out-of-range selects.
module demux_reg #(
    parameter int  NUM_OUTPUTS = 6,
    parameter int  DATA_WIDTH  = 8,
    localparam int SELECT_BITS = $clog2(NUM_OUTPUTS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [SELECT_BITS-1:0] i_select,
    output logic [NUM_OUTPUTS-1:0] o_valid,
    output logic [DATA_WIDTH-1:0]  o_data_bus [NUM_OUTPUTS],
    input  logic [NUM_OUTPUTS-1:0] i_ready,
    output logic                   o_err,
    output logic [7:0]             o_err_count
);

    localparam logic [SELECT_BITS:0] NUM_OUT_W = NUM_OUTPUTS[SELECT_BITS:0];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic sel_in_range(input logic [SELECT_BITS-1:0] s);
        return ({1'b0, s} < NUM_OUT_W);
    endfunction

    function automatic logic [NUM_OUTPUTS-1:0] sel_onehot(input logic v,
                                                          input logic [SELECT_BITS-1:0] s);
        logic [NUM_OUTPUTS-1:0] r;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (v && (SELECT_BITS'(k) == s)) begin
                r[k] = 1'b1;
            end else begin
                r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    logic                   hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]  hold_data_q,  hold_data_d;
    logic [SELECT_BITS-1:0] hold_sel_q,   hold_sel_d;
    logic                   err_q,        err_d;
    logic [7:0]             err_count_q,  err_count_d;
    logic [NUM_OUTPUTS-1:0] valid_out_q,  valid_out_d;
    logic [DATA_WIDTH-1:0]  data_out_q [NUM_OUTPUTS];
    logic [DATA_WIDTH-1:0]  data_out_d [NUM_OUTPUTS];

    logic ready_s;
    logic accept_s;
    logic legal_s;
    logic drain_s;

    // Handshake qualifiers; the held select is always in range, so indexing i_ready is safe.
    always_comb begin
        drain_s  = hold_valid_q && i_ready[hold_sel_q];
        ready_s  = !hold_valid_q || i_ready[hold_sel_q];
        legal_s  = sel_in_range(i_select);
        accept_s = i_valid && ready_s;
    end

    // Next-state for the holding entry, error accounting and the decoded output image.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_sel_d   = hold_sel_q;
        err_d        = err_q;
        err_count_d  = err_count_q;

        // An accept while FULL implies a drain, so a dropped word leaves the block EMPTY.
        if (accept_s && legal_s) begin
            hold_valid_d = 1'b1;
            hold_data_d  = i_data;
            hold_sel_d   = i_select;
        end else if (drain_s || accept_s) begin
            hold_valid_d = 1'b0;
            hold_data_d  = '0;
            hold_sel_d   = '0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (accept_s && !legal_s) begin
            err_d       = 1'b1;
            err_count_d = sat_inc8(err_count_q);
        end else begin
            err_d       = err_q;
        end

        valid_out_d = sel_onehot(hold_valid_d, hold_sel_d);
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (valid_out_d[k]) begin
                data_out_d[k] = hold_data_d;
            end else begin
                data_out_d[k] = '0;
            end
        end
    end

    // State and output registers; reset discards any held word immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_sel_q   <= '0;
            err_q        <= 1'b0;
            err_count_q  <= 8'd0;
            valid_out_q  <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                data_out_q[k] <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_sel_q   <= hold_sel_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            valid_out_q  <= valid_out_d;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                data_out_q[k] <= data_out_d[k];
            end
        end
    end

    assign o_ready     = ready_s;
    assign o_valid     = valid_out_q;
    assign o_data_bus  = data_out_q;
    assign o_err       = err_q;
    assign o_err_count = err_count_q;

endmodule

// File: tb/tb_demux_reg.sv
// Directed self-checking bench for demux_reg (6 outputs, 8-bit payload).
module tb_demux_reg;

    logic       clk;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic [2:0] i_select;
    logic [5:0] o_valid;
    logic [7:0] o_data_bus [6];
    logic [5:0] i_ready;
    logic       o_err;
    logic [7:0] o_err_count;

    logic [47:0] flat_s;
    int n_cmp;
    int n_err;
    int n_deliv;

    demux_reg dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_select   (i_select),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .i_ready    (i_ready),
        .o_err      (o_err),
        .o_err_count(o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port k occupies bits [8k+7:8k] of the flattened view.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            flat_s[8*k +: 8] = o_data_bus[k];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  sel;
        logic [7:0]  dat;
        logic [47:0] exp_flat;
        n_cmp = 0; n_err = 0; n_deliv = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_select = 3'd0; i_ready = 6'h3F;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 6'b000000);
        check("rst_data", flat_s, 48'h0);
        check("rst_err", o_err, 1'b0);
        check("rst_cnt", o_err_count, 8'd0);
        check("rst_ready", o_ready, 1'b1);
        i_rst = 1'b0;

        // Routing AA,BB,CC to ports 0,1,2
        i_valid = 1'b1; i_data = 8'hAA; i_select = 3'd0;
        tick();
        check("rt0_valid", o_valid, 6'b000001);
        check("rt0_data", flat_s, 48'h0000_0000_00AA);
        i_data = 8'hBB; i_select = 3'd1;
        tick();
        check("rt1_valid", o_valid, 6'b000010);
        check("rt1_data", flat_s, 48'h0000_0000_BB00);
        i_data = 8'hCC; i_select = 3'd2;
        tick();
        check("rt2_valid", o_valid, 6'b000100);
        check("rt2_data", flat_s, 48'h0000_00CC_0000);
        i_valid = 1'b0;
        tick();
        check("rt_drain", o_valid, 6'b000000);
        check("rt_drain_data", flat_s, 48'h0);

        // Backpressure: DD stalls on port 3 while EE waits upstream
        i_ready = 6'b110111; i_valid = 1'b1; i_data = 8'hDD; i_select = 3'd3;
        tick();
        check("bp_load_valid", o_valid, 6'b001000);
        i_data = 8'hEE; i_select = 3'd4;
        for (int i = 0; i < 5; i++) begin
            i_ready = i[0] ? 6'b000000 : 6'b110111;
            #1;
            check("bp_ready", o_ready, 1'b0);
            tick();
            check("bp_hold_valid", o_valid, 6'b001000);
            check("bp_hold_data", flat_s, 48'h0000_DD00_0000);
        end
        i_ready = 6'h3F;
        #1;
        check("bp_release_ready", o_ready, 1'b1);
        tick();
        check("bp_ee_valid", o_valid, 6'b010000);
        check("bp_ee_data", flat_s, 48'h00EE_0000_0000);
        i_valid = 1'b0;
        tick();
        check("bp_empty", o_valid, 6'b000000);

        // Illegal selects 7 and 6, then a legal word
        i_valid = 1'b1; i_data = 8'hFF; i_select = 3'd7;
        #1;
        check("il_ready", o_ready, 1'b1);
        tick();
        check("il7_valid", o_valid, 6'b000000);
        check("il7_data", flat_s, 48'h0);
        check("il7_err", o_err, 1'b1);
        check("il7_cnt", o_err_count, 8'd1);
        i_select = 3'd6;
        tick();
        check("il6_valid", o_valid, 6'b000000);
        check("il6_cnt", o_err_count, 8'd2);
        i_data = 8'h11; i_select = 3'd5;
        tick();
        check("il_legal_valid", o_valid, 6'b100000);
        check("il_legal_data", flat_s, 48'h1100_0000_0000);
        check("il_legal_err", o_err, 1'b1);
        check("il_legal_cnt", o_err_count, 8'd2);
        // Dropped word accepted while the held word drains
        i_data = 8'h22; i_select = 3'd7;
        #1;
        check("il_drain_ready", o_ready, 1'b1);
        tick();
        check("il_drain_valid", o_valid, 6'b000000);
        check("il_drain_data", flat_s, 48'h0);
        check("il_drain_cnt", o_err_count, 8'd3);

        // Saturation: 300 more illegal words
        i_select = 3'd6;
        repeat (300) tick();
        check("sat_cnt", o_err_count, 8'd255);
        check("sat_err", o_err, 1'b1);
        check("sat_valid", o_valid, 6'b000000);
        i_valid = 1'b0;

        // Reset between edges while FULL and stalled
        i_ready = 6'b111011; i_valid = 1'b1; i_data = 8'h5A; i_select = 3'd2;
        tick();
        check("mr_load_valid", o_valid, 6'b000100);
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check("mr_valid", o_valid, 6'b000000);
        check("mr_data", flat_s, 48'h0);
        check("mr_err", o_err, 1'b0);
        check("mr_cnt", o_err_count, 8'd0);
        check("mr_ready", o_ready, 1'b1);
        #1;
        i_rst = 1'b0; i_ready = 6'h3F;
        tick();
        check("mr_no_replay_valid", o_valid, 6'b000000);
        check("mr_no_replay_data", flat_s, 48'h0);
        i_valid = 1'b1; i_data = 8'h77; i_select = 3'd1;
        tick();
        check("mr_first_valid", o_valid, 6'b000010);
        check("mr_first_data", flat_s, 48'h0000_0000_7700);

        // Throughput: 100 random legal words back to back
        for (int i = 0; i < 100; i++) begin
            sel = 3'($urandom_range(5, 0));
            dat = 8'($urandom);
            i_valid = 1'b1; i_data = dat; i_select = sel;
            #1;
            check("tp_ready", o_ready, 1'b1);
            tick();
            exp_flat = 48'(dat) << (8 * int'(sel));
            check("tp_valid", o_valid, 6'b000001 << sel);
            check("tp_data", flat_s, exp_flat);
            if (o_valid != 6'b000000) begin
                n_deliv++;
            end
        end
        i_valid = 1'b0;
        tick();
        check("tp_end_valid", o_valid, 6'b000000);
        check("tp_deliveries", n_deliv, 100);
        check("tp_cnt", o_err_count, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
